// File: rtl/cpu_phase_gen_pkg.sv
// Shared definitions for the CPU-phase clock-enable generator: FSM state
// encoding, default divider and the phase-position decode used by the
// generator and by downstream bus clients that align to the same phases.
`timescale 1ns/1ps
package cpu_phase_gen_pkg;

  // Sequencer modes
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } phase_state_e;

  // 25 MHz / 14 ~= 1.786 MHz CPU clock
  localparam int unsigned DIV_DEFAULT   = 32'd14;
  localparam int unsigned CNT_W_DEFAULT = 32'd32;

  // One clk worth of phase outputs
  typedef struct packed {
    logic ph1_rising;
    logic ph1_falling;
    logic ph2_rising;
    logic ph2_falling;
    logic ph2;
  } phase_strb_t;

  // Strobes/level for position pos (0..div-1) of a CPU cycle; phase 2
  // starts at the half point.
  function automatic phase_strb_t phase_decode(input int unsigned pos,
                                               input int unsigned div);
    phase_strb_t s;
    int unsigned h;
    h             = div / 32'd2;
    s.ph1_rising  = (pos == 32'd0);
    s.ph1_falling = (pos == h - 32'd1);
    s.ph2_rising  = (pos == h);
    s.ph2_falling = (pos == div - 32'd1);
    s.ph2         = (pos >= h);
    return s;
  endfunction

endpackage

// File: rtl/cpu_phase_gen_if.sv
// CPU-phase bus: debug control in, phase strobes/flags/counter out.
// master = the phase generator, slave = a bus client / debug host.
`timescale 1ns/1ps
interface cpu_phase_gen_if #(
  parameter int unsigned CNT_W = 32
);
  logic             halt;
  logic             step;
  logic             ph1_rising;
  logic             ph1_falling;
  logic             ph2_rising;
  logic             ph2_falling;
  logic             ph2;
  logic             even_cycle;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  halt, step,
    output ph1_rising, ph1_falling, ph2_rising, ph2_falling, ph2,
           even_cycle, halted, cycle_count
  );

  modport slave (
    output halt, step,
    input  ph1_rising, ph1_falling, ph2_rising, ph2_falling, ph2,
           even_cycle, halted, cycle_count
  );
endinterface

// File: rtl/cpu_phase_gen.sv
// Divides the pixel clock by DIV into a two-phase 6502 bus cycle with
// single-clk edge strobes, an even/odd cycle flag, a completed-cycle
// counter and a halt/single-step facility that only stops on a cycle
// boundary. cnt_q holds the position that will be emitted on the next
// clk, so every output is a flop and the first ph1_rising appears on the
// first clk after reset is released.
`timescale 1ns/1ps
module cpu_phase_gen
  import cpu_phase_gen_pkg::*;
#(
  parameter int unsigned DIV   = DIV_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  cpu_phase_gen_if.master bus
);

  localparam int unsigned     CW       = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 32'd1);

  phase_state_e     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  phase_strb_t      out_q, out_d;
  logic             halted_q, halted_d;
  logic             even_q, even_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             emit_s;

  // Next-state: pick the mode, then emit and advance the phase position
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = '0;
    halted_d = 1'b0;
    even_d   = even_q;
    count_d  = count_q;
    emit_s   = 1'b0;

    case (state_q)
      ST_RUN, ST_STEP: begin
        // out_q.ph2_falling marks the clk on which halt is sampled
        if (out_q.ph2_falling && bus.halt) begin
          state_d  = ST_HALTED;
          cnt_d    = '0;
          halted_d = 1'b1;
        end else if (out_q.ph2_falling) begin
          state_d = ST_RUN;
          emit_s  = 1'b1;
        end else begin
          state_d = state_q;
          emit_s  = 1'b1;
        end
      end
      ST_HALTED: begin
        // Releasing halt wins over a coincident step
        if (!bus.halt) begin
          state_d = ST_RUN;
          emit_s  = 1'b1;
        end else if (bus.step) begin
          state_d = ST_STEP;
          emit_s  = 1'b1;
        end else begin
          halted_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    if (emit_s) begin
      out_d = phase_decode(32'(cnt_q), DIV);
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        even_d  = ~even_q;
        count_d = count_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      out_d = '0;
    end
  end

  // State, phase position and registered outputs; reset aborts any cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      out_q    <= '0;
      halted_q <= 1'b0;
      even_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      halted_q <= halted_d;
      even_q   <= even_d;
      count_q  <= count_d;
    end
  end

  assign bus.ph1_rising  = out_q.ph1_rising;
  assign bus.ph1_falling = out_q.ph1_falling;
  assign bus.ph2_rising  = out_q.ph2_rising;
  assign bus.ph2_falling = out_q.ph2_falling;
  assign bus.ph2         = out_q.ph2;
  assign bus.even_cycle  = even_q;
  assign bus.halted      = halted_q;
  assign bus.cycle_count = count_q;

endmodule

// File: tb/tb_cpu_phase_gen.sv
// Directed bench for cpu_phase_gen (DIV=14). Expected ph1_rising clk
// indices are queued when the stimulus that causes them is applied and
// popped by a monitor whenever the DUT emits one; levels/counters are
// compared at fixed clk indices relative to reset release.
`timescale 1ns/1ps
module tb_cpu_phase_gen;

  localparam int DIV = 14;

  logic clk = 1'b0;
  logic rst;

  always #20 clk = ~clk;

  cpu_phase_gen_if #(.CNT_W(32)) bus ();

  cpu_phase_gen #(.DIV(DIV), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int exp_ph1[$];
  int c_p1r = 0;
  int c_p1f = 0;
  int c_p2r = 0;
  int c_p2f = 0;
  int overlap = 0;

  // Free-running clk index
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (clk %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
    #2;
  endtask

  // Monitor: strobe counts, overlap detection and ph1_rising scoreboard
  always @(negedge clk) begin
    int n;
    n = int'(bus.ph1_rising) + int'(bus.ph1_falling) + int'(bus.ph2_rising) + int'(bus.ph2_falling);
    if (n > 1) overlap++;
    c_p1r = c_p1r + int'(bus.ph1_rising);
    c_p1f = c_p1f + int'(bus.ph1_falling);
    c_p2r = c_p2r + int'(bus.ph2_rising);
    c_p2f = c_p2f + int'(bus.ph2_falling);
    if (bus.ph1_rising === 1'b1) begin
      if (exp_ph1.size() == 0) check("ph1_unexpected_at", cyc, 0);
      else check("ph1_rising_time", cyc, exp_ph1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (clk %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int base2;
    int tot0;
    int t;

    rst = 1'b1;
    bus.halt = 1'b0;
    bus.step = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_strobes", {bus.ph1_rising, bus.ph1_falling, bus.ph2_rising, bus.ph2_falling, bus.ph2}, 5'b0);
    check("rst_even", bus.even_cycle, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_count", bus.cycle_count, 0);

    // Reset release and 100-cycle free run (plus the start of cycle 101)
    rst = 1'b0;
    base = cyc;
    for (int k = 0; k <= 100; k++) exp_ph1.push_back(base + 1 + 14 * k);
    wait_cyc(base + 1);
    check("first_ph1_rising", bus.ph1_rising, 1);
    wait_cyc(base + 7);
    check("ph1_falling_at7", bus.ph1_falling, 1);
    check("ph2_low_at7", bus.ph2, 0);
    wait_cyc(base + 8);
    check("ph2_rising_at8", bus.ph2_rising, 1);
    check("ph2_high_at8", bus.ph2, 1);
    wait_cyc(base + 14);
    check("ph2_falling_at14", bus.ph2_falling, 1);
    check("ph2_high_at14", bus.ph2, 1);
    check("count_after_1", bus.cycle_count, 1);
    wait_cyc(base + 15);
    check("ph2_low_at15", bus.ph2, 0);
    wait_cyc(base + 1400);
    check("count_100", bus.cycle_count, 100);
    check("even_100", bus.even_cycle, 0);
    check("n_ph1_rising", c_p1r, 100);
    check("n_ph1_falling", c_p1f, 100);
    check("n_ph2_rising", c_p2r, 100);
    check("n_ph2_falling", c_p2f, 100);
    check("overlap", overlap, 0);

    // Halt raised mid-cycle (cnt=3): the cycle completes, then stop
    wait_cyc(base + 1404);
    bus.halt = 1'b1;
    wait_cyc(base + 1414);
    check("halt_ph2_falling", bus.ph2_falling, 1);
    check("halt_not_yet", bus.halted, 0);
    check("halt_count", bus.cycle_count, 101);
    wait_cyc(base + 1415);
    check("halted_rise", bus.halted, 1);
    tot0 = c_p1r + c_p1f + c_p2r + c_p2f;
    wait_cyc(base + 1465);
    check("halted_no_strobes", c_p1r + c_p1f + c_p2r + c_p2f, tot0);
    check("halted_count_frozen", bus.cycle_count, 101);
    check("halted_held", bus.halted, 1);
    check("halted_even", bus.even_cycle, 1);

    // Three single steps, 30 clks apart, halt held high
    for (int i = 0; i < 3; i++) begin
      t = base + 1465 + 30 * i;
      wait_cyc(t);
      bus.step = 1'b1;
      exp_ph1.push_back(t + 1);
      @(posedge clk);
      #1 bus.step = 1'b0;
      wait_cyc(t + 1);
      check("step_halted_low", bus.halted, 0);
      wait_cyc(t + 14);
      check("step_ph2_falling", bus.ph2_falling, 1);
      check("step_halted_low_end", bus.halted, 0);
      wait_cyc(t + 15);
      check("step_halted_again", bus.halted, 1);
    end
    wait_cyc(base + 1545);
    check("step_count", bus.cycle_count, 104);
    check("step_even", bus.even_cycle, 0);

    // Halt dropped while halted
    wait_cyc(base + 1550);
    bus.halt = 1'b0;
    exp_ph1.push_back(base + 1551);
    wait_cyc(base + 1551);
    check("resume_halted_low", bus.halted, 0);
    check("resume_ph1", bus.ph1_rising, 1);
    wait_cyc(base + 1555);
    bus.halt = 1'b1;
    wait_cyc(base + 1565);
    check("rehalt", bus.halted, 1);
    check("rehalt_count", bus.cycle_count, 105);

    // Coincident step and halt release: plain RUN, no extra cycle
    wait_cyc(base + 1570);
    bus.halt = 1'b0;
    bus.step = 1'b1;
    exp_ph1.push_back(base + 1571);
    exp_ph1.push_back(base + 1585);
    exp_ph1.push_back(base + 1599);
    @(posedge clk);
    #1 bus.step = 1'b0;
    wait_cyc(base + 1571);
    check("coinc_halted_low", bus.halted, 0);
    wait_cyc(base + 1584);
    check("coinc_ph2_falling", bus.ph2_falling, 1);
    check("coinc_count", bus.cycle_count, 106);
    wait_cyc(base + 1598);
    check("run_count", bus.cycle_count, 107);

    // Reset during phase 2 (cnt=10)
    wait_cyc(base + 1609);
    check("pre_rst_ph2", bus.ph2, 1);
    rst = 1'b1;
    wait_cyc(base + 1610);
    check("midrst_strobes", {bus.ph1_rising, bus.ph1_falling, bus.ph2_rising, bus.ph2_falling, bus.ph2}, 5'b0);
    check("midrst_count", bus.cycle_count, 0);
    check("midrst_even", bus.even_cycle, 0);
    wait_cyc(base + 1612);
    check("midrst_no_ph2_falling", bus.ph2_falling, 0);
    wait_cyc(base + 1614);
    rst = 1'b0;
    base2 = cyc;
    exp_ph1.push_back(base2 + 1);
    exp_ph1.push_back(base2 + 15);
    exp_ph1.push_back(base2 + 29);
    wait_cyc(base2 + 7);
    check("restart_ph1_falling", bus.ph1_falling, 1);
    wait_cyc(base2 + 8);
    check("restart_ph2_rising", bus.ph2_rising, 1);
    check("restart_ph2", bus.ph2, 1);
    wait_cyc(base2 + 14);
    check("restart_ph2_falling", bus.ph2_falling, 1);
    check("restart_count", bus.cycle_count, 1);
    wait_cyc(base2 + 30);
    check("ph1_pending", exp_ph1.size(), 0);
    check("final_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
